// File: rtl/fnd_pkg.sv
// Shared definitions for the multi-channel FND display: segment codes,
// conversion state encoding and a BCD-digit-to-segment helper.
package fnd_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_LOAD  = 2'd1,
    CONV_SHIFT = 2'd2,
    CONV_DONE  = 2'd3
  } conv_state_t;

  // Active-low segments, bit7 = dp (kept off here), bits[6:0] = gfedcba
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_multi_channel_display_bin2bcd.sv
// Sequential double-dabble converter: LOAD, one iteration per SHIFT cycle,
// result valid for one cycle in DONE. abort_i restarts from LOAD.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              load_o,
  output logic              valid_o,
  output logic [15:0]       bcd_o,
  output logic              ovf_o
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(DATA_W - 1);

  conv_state_t       state_q, state_d, state_nxt_s;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d, bcd_adj_s;
  logic [CNT_W-1:0]  it_q, it_d;
  logic              ovf_q, ovf_d;

  // Add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    bcd_adj_s = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[k*4 +: 4] >= 4'd5) begin
        bcd_adj_s[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
      end else begin
        bcd_adj_s[k*4 +: 4] = bcd_q[k*4 +: 4];
      end
    end
  end

  // Conversion sequencing and datapath next-state
  always_comb begin
    state_nxt_s = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    it_d        = it_q;
    ovf_d       = ovf_q;
    case (state_q)
      CONV_IDLE: begin
        if (start_i) begin
          state_nxt_s = CONV_LOAD;
        end else begin
          state_nxt_s = CONV_IDLE;
        end
      end
      CONV_LOAD: begin
        bin_d       = bin_i;
        bcd_d       = 16'h0000;
        it_d        = {CNT_W{1'b0}};
        ovf_d       = (32'(bin_i) > 32'd9999);
        state_nxt_s = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        bcd_d = {bcd_adj_s[14:0], bin_q[DATA_W-1]};
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        it_d  = it_q + CNT_W'(1);
        if (it_q == LAST_IT) begin
          state_nxt_s = CONV_DONE;
        end else begin
          state_nxt_s = CONV_SHIFT;
        end
      end
      CONV_DONE: state_nxt_s = CONV_IDLE;
      default:   state_nxt_s = CONV_IDLE;
    endcase
    state_d = abort_i ? CONV_LOAD : state_nxt_s;
  end

  // Converter state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CONV_IDLE;
      bin_q   <= {DATA_W{1'b0}};
      bcd_q   <= 16'h0000;
      it_q    <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
      ovf_q   <= ovf_d;
    end
  end

  assign load_o  = (state_q == CONV_LOAD);
  assign valid_o = (state_q == CONV_DONE);
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/fnd_multi_channel_display.sv
// NUM_CH-channel 4-digit common-anode FND driver: manual/auto channel select,
// sequential BCD conversion, digit scan with zero blanking and channel dot.
module fnd_multi_channel_display
  import fnd_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 14,
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int ROTATE_MS = 3000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH*DATA_W-1:0]  ch_data_i,
  input  logic [NUM_CH-1:0]         ch_valid_i,
  input  logic                      btn_next_i,
  input  logic                      auto_en_i,
  output logic [$clog2(NUM_CH)-1:0] sel_ch_o,
  output logic [3:0]                fnd_com_o,
  output logic [7:0]                fnd_font_o
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int ROT   = CLK_HZ / 1000 * ROTATE_MS;
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int ROT_W = $clog2(ROT + 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT - 1);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ROT_W-1:0]  rot_q, rot_d;
  logic [DIV_W-1:0]  scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][7:0]   disp_q, disp_d;
  logic              vld_q, vld_d;
  logic [3:0]        com_q, com_d;
  logic [7:0]        font_q, font_d;
  logic              adv_s, tick_s;
  logic [DATA_W-1:0] cur_data_s;
  logic              cur_valid_s;
  logic              conv_load_s, conv_valid_s, conv_ovf_s;
  logic [15:0]       conv_bcd_s, shown_bcd_s;

  // Selected channel's data and valid flag
  always_comb begin
    cur_data_s  = {DATA_W{1'b0}};
    cur_valid_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_data_s  = (sel_q == SEL_W'(i)) ? ch_data_i[i*DATA_W +: DATA_W] : cur_data_s;
      cur_valid_s = (sel_q == SEL_W'(i)) ? ch_valid_i[i] : cur_valid_s;
    end
  end

  // A button press and a rotate terminal count in the same cycle merge into one advance
  assign adv_s  = btn_next_i || (auto_en_i && (rot_q == ROT_LAST));
  assign tick_s = (scan_q == DIV_LAST);

  // Channel select, rotate timer and scan counter next-state
  always_comb begin
    if (adv_s) begin
      sel_d = (sel_q == SEL_LAST) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1);
    end else begin
      sel_d = sel_q;
    end
    if (!auto_en_i || btn_next_i || (rot_q == ROT_LAST)) begin
      rot_d = {ROT_W{1'b0}};
    end else begin
      rot_d = rot_q + ROT_W'(1);
    end
    if (tick_s) begin
      scan_d = {DIV_W{1'b0}};
      idx_d  = idx_q + 2'd1;
    end else begin
      scan_d = scan_q + DIV_W'(1);
      idx_d  = idx_q;
    end
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W)
  ) u_bin2bcd (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (1'b1),
    .abort_i (adv_s),
    .bin_i   (cur_data_s),
    .load_o  (conv_load_s),
    .valid_o (conv_valid_s),
    .bcd_o   (conv_bcd_s),
    .ovf_o   (conv_ovf_s)
  );

  // Display register: blanked on channel change, otherwise rewritten only at DONE
  always_comb begin
    shown_bcd_s = conv_ovf_s ? 16'h9999 : conv_bcd_s;
    vld_d       = conv_load_s ? cur_valid_s : vld_q;
    disp_d      = disp_q;
    if (adv_s) begin
      disp_d = {4{SEG_BLANK}};
    end else if (conv_valid_s) begin
      if (!vld_q) begin
        disp_d = {4{SEG_DASH}};
      end else begin
        disp_d[0] = seg_encode(shown_bcd_s[3:0]);
        disp_d[1] = (shown_bcd_s[15:4] == 12'h000) ? SEG_BLANK : seg_encode(shown_bcd_s[7:4]);
        disp_d[2] = (shown_bcd_s[15:8] == 8'h00) ? SEG_BLANK : seg_encode(shown_bcd_s[11:8]);
        disp_d[3] = (shown_bcd_s[15:12] == 4'h0) ? SEG_BLANK : seg_encode(shown_bcd_s[15:12]);
      end
    end else begin
      disp_d = disp_q;
    end
  end

  // Scan outputs follow the upcoming digit index; dp marks the selected channel
  always_comb begin
    com_d = ~(4'b0001 << idx_d);
    if (int'(idx_d) == int'(sel_q)) begin
      font_d = disp_q[idx_d] & 8'h7F;
    end else begin
      font_d = disp_q[idx_d];
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q  <= {SEL_W{1'b0}};
      rot_q  <= {ROT_W{1'b0}};
      scan_q <= {DIV_W{1'b0}};
      idx_q  <= 2'd0;
      disp_q <= {4{SEG_BLANK}};
      vld_q  <= 1'b0;
      com_q  <= 4'b1110;
      font_q <= 8'hFF;
    end else begin
      sel_q  <= sel_d;
      rot_q  <= rot_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      vld_q  <= vld_d;
      com_q  <= com_d;
      font_q <= font_d;
    end
  end

  assign sel_ch_o   = sel_q;
  assign fnd_com_o  = com_q;
  assign fnd_font_o = font_q;

endmodule

// File: tb/tb_fnd_multi_channel_display.sv
// Randomised bench for fnd_multi_channel_display with a decimal-arithmetic
// display model compared every cycle, plus literal scenario checks.
module tb_fnd_multi_channel_display;
  localparam int NUM_CH = 3;
  localparam int DW     = 14;
  localparam int DIV    = 4;
  localparam int ROT    = 20;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_CH*DW-1:0] ch_data = '0;
  logic [NUM_CH-1:0]  ch_valid = 3'b111;
  logic               btn = 1'b0;
  logic               auto_en = 1'b0;
  logic [1:0]         sel;
  logic [3:0]         com;
  logic [7:0]         font;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // model: position in refresh loop (0 idle, 1 load, 2..15 shift, 16 done)
  int         m_sel, m_rot, m_scan, m_idx, m_pos, m_val;
  bit         m_vld;
  logic [7:0] m_disp [4];
  logic [3:0] e_com;
  logic [7:0] e_font;
  int         e_sel;

  fnd_multi_channel_display #(
    .NUM_CH(NUM_CH), .DATA_W(DW), .CLK_HZ(1000), .SCAN_HZ(250), .ROTATE_MS(20)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .btn_next_i(btn), .auto_en_i(auto_en), .sel_ch_o(sel),
    .fnd_com_o(com), .fnd_font_o(font)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic render(input int v_in, input bit vld);
    int v, p;
    v = v_in;
    if (!vld) begin
      for (int i = 0; i < 4; i++) m_disp[i] = 8'hBF;
    end else begin
      if (v > 9999) v = 9999;
      p = 1;
      for (int i = 0; i < 4; i++) begin
        if (i > 0 && v < p) m_disp[i] = 8'hFF;
        else m_disp[i] = seg_tab[(v / p) % 10];
        p = p * 10;
      end
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_rot = 0; m_scan = 0; m_idx = 0; m_pos = 0; m_val = 0; m_vld = 1'b0;
    for (int i = 0; i < 4; i++) m_disp[i] = 8'hFF;
    e_com = 4'b1110; e_font = 8'hFF; e_sel = 0;
  endtask

  task automatic model_step();
    bit adv;
    int idx_n;
    adv   = btn || (auto_en && m_rot == ROT - 1);
    idx_n = (m_scan == DIV - 1) ? (m_idx + 1) % 4 : m_idx;
    e_com  = ~(4'b0001 << idx_n);
    e_font = m_disp[idx_n];
    if (idx_n == m_sel) e_font[7] = 1'b0;
    if (adv) begin
      for (int i = 0; i < 4; i++) m_disp[i] = 8'hFF;
      m_pos = 1;
    end else if (m_pos == 0) begin
      m_pos = 1;
    end else if (m_pos == 1) begin
      m_val = int'(ch_data[m_sel*DW +: DW]);
      m_vld = ch_valid[m_sel];
      m_pos = 2;
    end else if (m_pos < 16) begin
      m_pos++;
    end else begin
      render(m_val, m_vld);
      m_pos = 0;
    end
    m_rot  = (!auto_en || btn || m_rot == ROT - 1) ? 0 : m_rot + 1;
    m_scan = (m_scan + 1) % DIV;
    m_idx  = idx_n;
    if (adv) m_sel = (m_sel + 1) % NUM_CH;
    e_sel = m_sel;
  endtask

  // per-cycle compare against the model
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (chk_en) begin
      chk("com", int'(com), int'(e_com));
      chk("font", int'(font), int'(e_font));
      chk("sel", int'(sel), e_sel);
    end
  end

  task automatic pulse();
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic check_digits(input string name, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
    logic [7:0] exp_d [4];
    bit seen [4];
    int idx, n;
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    n = 0;
    while (!(seen[0] && seen[1] && seen[2] && seen[3]) && n < 24) begin
      @(negedge clk);
      n++;
      case (com)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0 && !seen[idx]) begin
        seen[idx] = 1'b1;
        chk({name, "_digit", 8'(48 + idx)}, int'(font), int'(exp_d[idx]));
      end
    end
    chk({name, "_scan_complete"}, int'(seen[0] && seen[1] && seen[2] && seen[3]), 1);
  endtask

  task automatic count_to_change(input string name, input int exp_n);
    logic [1:0] s0;
    int n;
    s0 = sel;
    n = 0;
    while (sel == s0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp_n);
  endtask

  initial begin
    int k, v, s_prev;
    repeat (3) @(negedge clk);
    chk("reset_com", int'(com), 32'h0000000E);
    chk("reset_font", int'(font), 32'h000000FF);
    chk("reset_sel", int'(sel), 0);
    ch_data[0 +: DW] = 14'd1234;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (40) @(negedge clk);
    check_digits("val1234", 8'hF9, 8'hA4, 8'hB0, 8'h19);

    ch_data[0 +: DW] = 14'd7;
    repeat (40) @(negedge clk);
    check_digits("val7", 8'hFF, 8'hFF, 8'hFF, 8'h78);

    ch_data[0 +: DW] = 14'd12000;
    repeat (40) @(negedge clk);
    check_digits("sat", 8'h90, 8'h90, 8'h90, 8'h10);

    ch_valid = 3'b101;
    ch_data[DW +: DW] = 14'd55;
    pulse();
    chk("wrap_sel1", int'(sel), 1);
    repeat (40) @(negedge clk);
    check_digits("dash", 8'hBF, 8'hBF, 8'h3F, 8'hBF);
    pulse();
    chk("wrap_sel2", int'(sel), 2);
    pulse();
    chk("wrap_sel0", int'(sel), 0);
    ch_valid = 3'b111;

    auto_en = 1'b1;
    count_to_change("auto_period", 20);
    repeat (15) @(negedge clk);
    s_prev = int'(sel);
    pulse();
    chk("btn_at15_sel", int'(sel), (s_prev + 1) % NUM_CH);
    count_to_change("auto_after_btn", 20);
    repeat (19) @(negedge clk);
    s_prev = int'(sel);
    pulse();
    chk("coincident_sel", int'(sel), (s_prev + 1) % NUM_CH);
    count_to_change("auto_after_coincident", 20);
    auto_en = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      btn = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 49) == 0) begin
        k = int'($urandom_range(0, NUM_CH - 1));
        case ($urandom_range(0, 3))
          0:       v = int'($urandom_range(0, 9));
          1:       v = int'($urandom_range(0, 999));
          2:       v = int'($urandom_range(0, 9999));
          default: v = int'($urandom_range(0, 16383));
        endcase
        ch_data[k*DW +: DW] = DW'(v);
      end
      if ($urandom_range(0, 99) == 0) begin
        k = int'($urandom_range(0, NUM_CH - 1));
        ch_valid[k] = ~ch_valid[k];
      end
    end
    btn = 1'b0;

    auto_en = 1'b1;
    k = 0;
    while (!(m_pos >= 2 && m_pos <= 15) && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_com", int'(com), 32'h0000000E);
    chk("async_font", int'(font), 32'h000000FF);
    chk("async_sel", int'(sel), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
